traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//  Phase sequencer for the single-road traffic light. It sits upstream of the countdown counter
//  and consumes its last/count_out. It drives the counter's en and one-hot init, and produces the
//  lamp and pedestrian-walk outputs. Cycle is GREEN -> YELLOW -> RED, with pedestrian green
//  shortening and a night flashing-yellow mode.
// PARAMETERS
//  pCNT_WIDTH      5  width of cnt_value (must match counter)
//  pINIT_WIDTH     3  width of cnt_init; bit0=GREEN, bit1=YELLOW, bit2=RED
//  pPED_GREEN_REM  4  green is cut short by a ped request only while cnt_value > this
// PORTS
//  clk        in   1            clock
//  rst_n      in   1            asynchronous, active-low reset
//  tick       in   1            1-clk strobe, 1 Hz time base
//  ped_req    in   1            async pedestrian button, level
//  night      in   1            night-mode enable, level, synchronous to clk
//  cnt_last   in   1            counter count == 0
//  cnt_value  in   pCNT_WIDTH   counter count_out
//  cnt_en     out  1            counter enable (combinational)
//  cnt_init   out  pINIT_WIDTH  one-hot counter load, valid only with cnt_en (combinational)
//  lamp       out  3            registered {red,yellow,green}
//  ped_walk   out  1            registered, 1 while state==RED
//  ped_pend   out  1            registered, latched pedestrian request
// BEHAVIOUR
//  - Reset: state=GREEN, lamp=3'b001, ped_walk=0, ped_pend=0, flash_ph=0.
//    The counter self-resets to its green value, so no load is issued at reset.
//  - States: GREEN, YELLOW, RED, FLASH. All transitions occur only on cycles with tick=1.
//  - Counter contract: the counter updates only when en=1, so every load drives cnt_en=1 and the
//    cnt_init one-hot bit in the same cycle.
//  - cnt_en = tick & (state!=FLASH), OR'd with 1 whenever a load is issued.
//  - cnt_init = 0 on every cycle with no load.
//  - Priority on a tick cycle, highest first:
//     1 night=1 & state!=FLASH: -> FLASH. No load. cnt_en=0. ped_pend cleared.
//     2 state==FLASH & night=0: -> RED. Load RED (cnt_init=3'b100, cnt_en=1).
//     3 GREEN & (cnt_last | (ped_pend & cnt_value>pPED_GREEN_REM)): -> YELLOW, load 3'b010.
//     4 YELLOW & cnt_last: -> RED, load 3'b100. ped_pend cleared on entry to RED.
//     5 RED & cnt_last: -> GREEN, load 3'b001.
//     6 otherwise: hold state. cnt_en=tick, which decrements the counter.
//  - Timing: a phase loaded with value N lasts N+1 ticks. lamp and ped_walk change at the clock
//    edge that performs the load.
//  - FLASH: lamp = {1'b0, flash_ph, 1'b0}. flash_ph toggles every tick and is cleared on exit.
//    The counter is frozen (cnt_en=0).
//  - ped_req: passed through a 2-flop synchronizer, then rising-edge detected.
//    The edge sets ped_pend in GREEN or YELLOW. It is ignored in RED and FLASH.
//    A set and a clear in the same cycle resolve to clear.
//  - cnt_last with no tick: no action; the counter holds at 0 and last stays asserted.
//  - The unused state encoding is recovered to GREEN with load 3'b001 on the next tick.
//  - rst_n asserted mid-phase: immediate return to the reset values above (async).
// STRUCTURE
//  - Package traffic_pkg: state enum/localparams (GREEN, YELLOW, RED, FLASH).
//    It also holds the init bit indices GREEN_IDX=0, YELLOW_IDX=1, RED_IDX=2 and the lamp encodings.
//  - Sub-module ped_sync_edge: 2-flop synchronizer plus rising-edge pulse for ped_req.
//  - Top: state register, ped_pend flop, flash_ph flop, combinational next-state/load logic.
//  - The bench instantiates this block together with the counter (14/2/17), tick every 4 clk.
// TESTING
//  1 Reset release, no inputs -> lamp=001 for 15 ticks.
//    On the 15th tick: cnt_en=1, cnt_init=010, lamp=010 next clk.
//  2 Full cycle -> YELLOW lasts 3 ticks, RED lasts 18 ticks with ped_walk=1, then GREEN load 001.
//    Period is 36 ticks.
//  3 ped_req pulse while green count=10 -> ped_pend=1.
//    Next tick: YELLOW load, ped_pend cleared at RED entry.
//  4 ped_req while green count=3 (<=4) -> no early cut; YELLOW only at count 0.
//  5 night=1 in RED -> FLASH at next tick; lamp alternates 000/010 per tick; counter frozen.
//    night=0 -> RED load 100.
//  6 night and ped edge on the same tick, plus rst_n pulse mid-YELLOW -> night wins with ped_pend=0.
//    After reset: lamp=001, counter=14.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light phase sequencer.
//   state_e      : phase state encoding (GREEN, YELLOW, RED, FLASH)
//   *_IDX        : bit positions of the counter's one-hot init vector
//   INIT_*       : one-hot counter load patterns
//   LAMP_*       : lamp encodings, {red, yellow, green}
//   lamp_of()    : lamp pattern for a given state and flash phase
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2,
        FLASH  = 2'd3
    } state_e;

    localparam int unsigned GREEN_IDX  = 0;
    localparam int unsigned YELLOW_IDX = 1;
    localparam int unsigned RED_IDX    = 2;

    localparam logic [2:0] INIT_GREEN  = 3'(1 << GREEN_IDX);
    localparam logic [2:0] INIT_YELLOW = 3'(1 << YELLOW_IDX);
    localparam logic [2:0] INIT_RED    = 3'(1 << RED_IDX);

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    function automatic logic [2:0] lamp_of(input state_e st, input logic flash_ph);
        case (st)
            GREEN:   return LAMP_GREEN;
            YELLOW:  return LAMP_YELLOW;
            RED:     return LAMP_RED;
            FLASH:   return {1'b0, flash_ph, 1'b0};
            default: return LAMP_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/ped_sync_edge.sv
// Pedestrian button conditioner: 2-flop synchronizer followed by a rising-edge detector.
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   ped_req  in  asynchronous button level
//   ped_rise out one-clock pulse on a synchronized 0->1 transition
module ped_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ped_req,
    output logic ped_rise
);

    // [0],[1] synchronizer stages, [2] previous synchronized value
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], ped_req};
        end
    end

    assign ped_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Phase sequencer for a single-road traffic light: GREEN -> YELLOW -> RED, with pedestrian
// green shortening and a night flashing-yellow mode. Drives an external countdown counter.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   tick       in   1-clk strobe, 1 Hz time base; all transitions happen on tick cycles
//   ped_req    in   asynchronous pedestrian button level
//   night      in   night-mode enable (synchronous level)
//   cnt_last   in   counter has reached zero
//   cnt_value  in   current counter value
//   cnt_en     out  counter enable (combinational)
//   cnt_init   out  one-hot counter load, meaningful only with cnt_en (combinational)
//   lamp       out  registered {red, yellow, green}
//   ped_walk   out  registered, high while in RED
//   ped_pend   out  registered, latched pedestrian request
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned pCNT_WIDTH     = 5,
    parameter int unsigned pINIT_WIDTH    = 3,
    parameter int unsigned pPED_GREEN_REM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic                   ped_req,
    input  logic                   night,
    input  logic                   cnt_last,
    input  logic [pCNT_WIDTH-1:0]  cnt_value,
    output logic                   cnt_en,
    output logic [pINIT_WIDTH-1:0] cnt_init,
    output logic [2:0]             lamp,
    output logic                   ped_walk,
    output logic                   ped_pend
);

    localparam logic [pCNT_WIDTH-1:0] PED_REM = pCNT_WIDTH'(pPED_GREEN_REM);

    state_e                 state_q, state_d;
    logic                   flash_ph_q, flash_ph_d;
    logic                   ped_pend_q, ped_pend_d;
    logic [2:0]             lamp_q, lamp_d;
    logic                   ped_walk_q, ped_walk_d;
    logic [pINIT_WIDTH-1:0] init_d;
    logic                   pend_clr;
    logic                   ped_rise;

    ped_sync_edge u_ped_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .ped_req  (ped_req),
        .ped_rise (ped_rise)
    );

    always_comb begin
        state_d    = state_q;
        init_d     = '0;
        flash_ph_d = flash_ph_q;
        pend_clr   = 1'b0;
        if (tick) begin
            if (night && (state_q != FLASH)) begin
                // Counter is left as-is; it is reloaded with RED on exit.
                state_d  = FLASH;
                pend_clr = 1'b1;
            end else begin
                case (state_q)
                    GREEN: begin
                        if (cnt_last || (ped_pend_q && (cnt_value > PED_REM))) begin
                            state_d = YELLOW;
                            init_d  = pINIT_WIDTH'(INIT_YELLOW);
                        end
                    end
                    YELLOW: begin
                        if (cnt_last) begin
                            state_d  = RED;
                            init_d   = pINIT_WIDTH'(INIT_RED);
                            pend_clr = 1'b1;
                        end
                    end
                    RED: begin
                        if (cnt_last) begin
                            state_d = GREEN;
                            init_d  = pINIT_WIDTH'(INIT_GREEN);
                        end
                    end
                    FLASH: begin
                        if (!night) begin
                            state_d    = RED;
                            init_d     = pINIT_WIDTH'(INIT_RED);
                            flash_ph_d = 1'b0;
                        end else begin
                            flash_ph_d = ~flash_ph_q;
                        end
                    end
                    default: begin
                        state_d = GREEN;
                        init_d  = pINIT_WIDTH'(INIT_GREEN);
                    end
                endcase
            end
        end

        // A load always implies enable; otherwise the counter decrements on ticks outside
        // FLASH, except on the tick that enters FLASH.
        cnt_en = (tick && (state_q != FLASH) && !night) || (init_d != '0);

        // Clear has priority over a coincident set.
        ped_pend_d = ped_pend_q;
        if (ped_rise && ((state_q == GREEN) || (state_q == YELLOW))) begin
            ped_pend_d = 1'b1;
        end
        if (pend_clr) begin
            ped_pend_d = 1'b0;
        end

        lamp_d     = lamp_of(state_d, flash_ph_d);
        ped_walk_d = (state_d == RED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GREEN;
            flash_ph_q <= 1'b0;
            ped_pend_q <= 1'b0;
            lamp_q     <= LAMP_GREEN;
            ped_walk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            flash_ph_q <= flash_ph_d;
            ped_pend_q <= ped_pend_d;
            lamp_q     <= lamp_d;
            ped_walk_q <= ped_walk_d;
        end
    end

    assign cnt_init = init_d;
    assign lamp     = lamp_q;
    assign ped_walk = ped_walk_q;
    assign ped_pend = ped_pend_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl together with a countdown counter model (green 14, yellow 2,
// red 17). Tick is strobed every 4 clocks. Each tick applies one table record; the expected
// outputs are queued when the tick is driven and popped/compared after the clock edge.
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic       cnt_last;
    logic [4:0] cnt_value;
    logic       cnt_en;
    logic [2:0] cnt_init;
    logic [2:0] lamp;
    logic       ped_walk;
    logic       ped_pend;
    logic [4:0] cnt_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       night;
        logic       ped;    // press the button in the idle window after this tick
        logic       en;
        logic [2:0] init;
        logic [2:0] lamp;
        logic       walk;
        logic       pend;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .pCNT_WIDTH     (5),
        .pINIT_WIDTH    (3),
        .pPED_GREEN_REM (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .ped_req   (ped_req),
        .night     (night),
        .cnt_last  (cnt_last),
        .cnt_value (cnt_value),
        .cnt_en    (cnt_en),
        .cnt_init  (cnt_init),
        .lamp      (lamp),
        .ped_walk  (ped_walk),
        .ped_pend  (ped_pend)
    );

    // Countdown counter: loads on a one-hot init, otherwise decrements to 0 and holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 5'd14;
        end else if (cnt_en) begin
            case (cnt_init)
                3'b001:  cnt_q <= 5'd14;
                3'b010:  cnt_q <= 5'd2;
                3'b100:  cnt_q <= 5'd17;
                default: cnt_q <= (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
            endcase
        end
    end
    assign cnt_last  = (cnt_q == 5'd0);
    assign cnt_value = cnt_q;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic add(input int n, input logic nt, input logic pd, input logic en,
                       input logic [2:0] ini, input logic [2:0] lmp, input logic wk,
                       input logic pn);
        vec_t v;
        v = '{night: nt, ped: pd, en: en, init: ini, lamp: lmp, walk: wk, pend: pn};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // One tick cycle followed by three idle clocks.
    task automatic apply(input vec_t v, input string name);
        logic       cap_en;
        logic [2:0] cap_init;
        logic [8:0] exp;
        @(negedge clk);
        tick  = 1'b1;
        night = v.night;
        #1;
        cap_en   = cnt_en;
        cap_init = cnt_init;
        exp_q.push_back({v.en, v.init, v.lamp, v.walk, v.pend});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check(name, {cap_en, cap_init, lamp, ped_walk, ped_pend}, exp);
        @(negedge clk);
        tick    = 1'b0;
        ped_req = v.ped;
        #1;
        check({name, "_idle"}, {5'd0, cnt_en, cnt_init}, 9'd0);
        repeat (2) @(negedge clk);
        ped_req = 1'b0;
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[i]) apply(vecs[i], $sformatf("%s[%0d]", tag, i));
        vecs.delete();
    endtask

    // Shorthands for recurring records: {night,ped,en,init,lamp,walk,pend}
    task automatic green_hold(input int n, input logic pn);
        add(n, 1'b0, 1'b0, 1'b1, 3'b000, 3'b001, 1'b0, pn);
    endtask
    task automatic red_hold(input int n);
        add(n, 1'b0, 1'b0, 1'b1, 3'b000, 3'b100, 1'b1, 1'b0);
    endtask
    task automatic green_load();
        add(1, 1'b0, 1'b0, 1'b1, 3'b001, 3'b001, 1'b0, 1'b0);
    endtask
    task automatic red_load();
        add(1, 1'b0, 1'b0, 1'b1, 3'b100, 3'b100, 1'b1, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check("reset", {1'b0, cnt_en, cnt_init, lamp, ped_walk, ped_pend},
              {1'b0, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // Full cycle: 15 green, 3 yellow, 18 red, back to green
        green_hold(14, 1'b0);
        add(1, 1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0);
        add(2, 1'b0, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 1'b0);
        red_load();
        red_hold(17);
        green_load();
        run_table("cycle");
        check("green_reload_cnt", {4'd0, cnt_q}, {4'd0, 5'd14});

        // Pedestrian request at green count 10 cuts green short
        green_hold(3, 1'b0);
        add(1, 1'b0, 1'b1, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0);
        add(1, 1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 1'b1);
        add(2, 1'b0, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 1'b1);
        red_load();
        red_hold(17);
        green_load();
        run_table("ped_cut");

        // Pedestrian request at green count 3 does not cut green
        green_hold(10, 1'b0);
        add(1, 1'b0, 1'b1, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0);
        green_hold(3, 1'b1);
        add(1, 1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 1'b1);
        add(2, 1'b0, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 1'b1);
        red_load();
        red_hold(2);
        run_table("ped_late");

        // Night mode from RED: flashing yellow, counter frozen, button ignored
        add(1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0);
        add(1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0);
        run_table("flash");
        check("flash_frozen_cnt", {4'd0, cnt_q}, {4'd0, 5'd15});
        red_load();
        red_hold(17);
        green_load();
        add(1, 1'b0, 1'b1, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0);
        add(1, 1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 1'b1);
        add(1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 1'b1);
        run_table("flash_exit");

        // Night and a pedestrian edge on the same tick, in YELLOW with ped_pend set:
        // the edge pulse is timed to coincide with the tick cycle.
        ped_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick  = 1'b1;
        night = 1'b1;
        #1;
        check("night_ped_comb", {5'd0, cnt_en, cnt_init}, 9'd0);
        @(posedge clk);
        #1;
        check("night_ped_state", {4'd0, lamp, ped_walk, ped_pend}, {4'd0, 3'b000, 1'b0, 1'b0});
        @(negedge clk);
        tick    = 1'b0;
        ped_req = 1'b0;
        repeat (2) @(negedge clk);

        red_load();
        red_hold(17);
        green_load();
        add(1, 1'b0, 1'b1, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0);
        add(1, 1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 1'b1);
        add(1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 1'b1);
        run_table("pre_reset");

        // Asynchronous reset in the middle of YELLOW
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset", {4'd0, lamp, ped_walk, ped_pend}, {4'd0, 3'b001, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        green_hold(1, 1'b0);
        run_table("post_reset");
        check("post_reset_cnt", {4'd0, cnt_q}, {4'd0, 5'd13});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
